mha_result_collector: RTL and testbench
=======================================

# mha_result_collector

Output-side stage directly downstream of the ping-pong matmul controller and systolic wrapper. Captures each BLOCK_SIZE×BLOCK_SIZE result tile on the rising edge of the accumulator-done signal and assembles COL_Y tiles into one output row. Rows are held in two row buffers, so capture continues while the previous row drains. Completed rows leave as a tile-by-tile valid/ready stream toward the next Multi-Head Attention stage.

## Interface
- DATA_WIDTH, 16, bits per fixed-point element
- BLOCK_SIZE, 2, tile edge; tile = BLOCK_SIZE*BLOCK_SIZE elements
- COL_Y, 2, tiles per output row (matches controller COL_Y); must be ≥1
- TILE_W (localparam), DATA_WIDTH*BLOCK_SIZE*BLOCK_SIZE
- CIDX_W (localparam), max(1, $clog2(COL_Y))

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- acc_done_wrap  in  1  accumulator-done level from systolic wrapper
- in_tile  in  TILE_W  accumulated tile, valid in the cycle acc_done_wrap rises
- m_valid  out  1  output tile valid
- m_ready  in  1  consumer accepts tile when m_valid & m_ready
- m_data  out  TILE_W  output tile
- m_col_idx  out  CIDX_W  column index of m_data within its row
- m_last  out  1  high with the final tile (col COL_Y-1) of a row
- overflow  out  1  sticky; a tile was dropped
- drop_count  out  16  dropped tiles (see Configuration)
- rows_out  out  16  rows fully drained (see Configuration)

## Operation
- Edge detect: acc_done_d registers acc_done_wrap. Capture event = acc_done_wrap & ~acc_done_d. in_tile is sampled on that same clock edge.
- Two row buffers buf[0..1][0..COL_Y-1], each TILE_W wide. Per-buffer full flag buf_full[1:0]; pointers wr_sel, wr_col, rd_sel, rd_col.
- Capture with free = ~buf_full[wr_sel] | release_wr:
  - Writes buf[wr_sel][wr_col] and increments wr_col.
  - At wr_col == COL_Y-1: sets buf_full[wr_sel], wr_col wraps to 0, wr_sel toggles.
- Capture when not free: tile discarded, overflow ← 1, drop_count increments, pointers unchanged.
- release_wr: same-cycle release of the buffer at wr_sel by the final handshake. A capture in that cycle is accepted.
- Drain FSM, 2 states:
  - S_IDLE: m_valid = 0. Moves to S_DRAIN when buf_full[rd_sel] = 1.
  - S_DRAIN: m_valid = 1, m_data = buf[rd_sel][rd_col], m_col_idx = rd_col, m_last = (rd_col == COL_Y-1).
  - Handshake in S_DRAIN with rd_col < COL_Y-1: rd_col increments.
  - Handshake with m_last: clears buf_full[rd_sel], rd_col ← 0, rd_sel toggles, rows_out increments. Goes to S_DRAIN if the other buffer is already full (back-to-back rows, no bubble), else S_IDLE.
- AXI-stream rules: once m_valid is high, m_data, m_col_idx and m_last hold until the handshake. m_valid never drops without a handshake.
- Counters saturate at 16'hFFFF. overflow clears only on reset.
- COL_Y = 1: every capture fills a row; m_last is constantly 1 in S_DRAIN.

## Timing
- Reset (async assert, sync-safe deassert):
  - m_valid = 0, m_last = 0, m_col_idx = 0, m_data = 0, overflow = 0, drop_count = 0, rows_out = 0.
  - Pointers = 0, buf_full = 0, FSM = S_IDLE, acc_done_d = 0.
- Reset mid-operation discards all buffered tiles and any in-flight row. No partial output after release.
- Latency: the last tile of a row captured at edge N raises m_valid after edge N+1.
- With m_ready held high, a row drains in COL_Y cycles; throughput is 1 tile/cycle.
- acc_done_wrap held high for multiple cycles produces exactly one capture. It must fall before the next tile can be captured.

## Configuration
- MHA_COLLECTOR_PERF_CNT_EN defined: drop_count and rows_out counters are implemented as described.
- MHA_COLLECTOR_PERF_CNT_EN not defined: both ports are tied to 16'd0 and no counter flops exist. overflow and all datapath behaviour are unchanged.

## Test plan
- Basic row, COL_Y=2, m_ready=1: two acc_done pulses with tiles 0xA…, 0xB… → m_valid 1 cycle after 2nd capture; col 0 = 0xA…, then col 1 = 0xB… with m_last=1; rows_out=1.
- Backpressure: m_ready=0 for 10 cycles after m_valid → m_data/m_col_idx stay constant; release → both tiles delivered once, in order.
- Overflow: m_ready=0, 5 captures with COL_Y=2 → both buffers full, 5th tile dropped; overflow=1, drop_count=1; later drain outputs tiles 1–4 only.
- Simultaneous release/capture: both full, final handshake of row 0 in the same cycle as a capture → capture accepted into freed buffer, overflow stays 0.
- Level-held acc_done_wrap high 6 cycles → exactly one capture (wr_col advances by 1).
- Async reset asserted mid-drain → m_valid=0 immediately; after reset, new row drains from col 0 with no stale tiles.

Source files
------------

// File: rtl/mha_result_collector.sv
// mha_result_collector
// Captures result tiles from the systolic wrapper on each rising edge of
// acc_done_wrap, assembles COL_Y tiles per row in a pair of row buffers, and
// streams completed rows out tile by tile over a valid/ready handshake.
// Optional feature macro: MHA_COLLECTOR_PERF_CNT_EN (drop_count / rows_out
// counters; when undefined both ports are tied to zero).
module mha_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int COL_Y      = 2,
    localparam int TILE_W    = DATA_WIDTH * BLOCK_SIZE * BLOCK_SIZE,
    localparam int CIDX_W    = (COL_Y > 1) ? $clog2(COL_Y) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_done_wrap,
    input  logic [TILE_W-1:0] in_tile,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [TILE_W-1:0] m_data,
    output logic [CIDX_W-1:0] m_col_idx,
    output logic              m_last,
    output logic              overflow,
    output logic [15:0]       drop_count,
    output logic [15:0]       rows_out
);

    localparam logic [CIDX_W-1:0] LAST_COL = CIDX_W'(COL_Y - 1);

    // Drain FSM encoding kept as plain constants for legacy compatibility
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nx;

    logic              acc_done_d;
    logic              capture;

    logic [TILE_W-1:0] row_buf [2][COL_Y];
    logic [1:0]        buf_full;
    logic [1:0]        buf_full_nx;

    logic              wr_sel;
    logic [CIDX_W-1:0] wr_col;
    logic              rd_sel;
    logic [CIDX_W-1:0] rd_col;

    logic              handshake;
    logic              row_done;
    logic              release_wr;
    logic              free;
    logic              accept;
    logic              drop;
    logic              wr_row_done;

    assign capture     = acc_done_wrap & ~acc_done_d;

    assign handshake   = (state == S_DRAIN) & m_ready;
    assign row_done    = handshake & (rd_col == LAST_COL);
    // The buffer being released by the final handshake may take a new tile
    // in the very same cycle.
    assign release_wr  = row_done & (rd_sel == wr_sel);
    assign free        = ~buf_full[wr_sel] | release_wr;
    assign accept      = capture & free;
    assign drop        = capture & ~free;
    assign wr_row_done = accept & (wr_col == LAST_COL);

    // Delay the done level so a held-high level yields a single capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_done_d <= 1'b0;
        end else begin
            acc_done_d <= acc_done_wrap;
        end
    end

    // Tile storage; contents are only observable while their buffer is full
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf[wr_sel][wr_col] <= in_tile;
        end
    end

    // Write pointer advances per accepted tile and flips buffers per row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel <= 1'b0;
            wr_col <= '0;
        end else if (accept) begin
            if (wr_row_done) begin
                wr_col <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wr_col <= wr_col + CIDX_W'(1);
            end
        end
    end

    // Full flags: release first, then fill, so a same-cycle refill wins
    always_comb begin
        buf_full_nx = buf_full;
        if (row_done) begin
            buf_full_nx[rd_sel] = 1'b0;
        end
        if (wr_row_done) begin
            buf_full_nx[wr_sel] = 1'b1;
        end
    end

    // Register the full flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= '0;
        end else begin
            buf_full <= buf_full_nx;
        end
    end

    // Read pointer walks columns on each handshake and flips per row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel <= 1'b0;
            rd_col <= '0;
        end else if (handshake) begin
            if (row_done) begin
                rd_col <= '0;
                rd_sel <= ~rd_sel;
            end else begin
                rd_col <= rd_col + CIDX_W'(1);
            end
        end
    end

    // Drain FSM next state: back-to-back rows when the other buffer is ready
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (buf_full[rd_sel]) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (row_done) begin
                    state_nx = buf_full[~rd_sel] ? S_DRAIN : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Drain FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign m_valid   = (state == S_DRAIN);
    assign m_data    = m_valid ? row_buf[rd_sel][rd_col] : '0;
    assign m_col_idx = m_valid ? rd_col : '0;
    assign m_last    = m_valid & (rd_col == LAST_COL);

`ifdef MHA_COLLECTOR_PERF_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] rows_cnt;

    // Saturating drop and drained-row counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            rows_cnt <= '0;
        end else begin
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (row_done && (rows_cnt != 16'hFFFF)) begin
                rows_cnt <= rows_cnt + 16'd1;
            end
        end
    end

    assign drop_count = drop_cnt;
    assign rows_out   = rows_cnt;
`else
    assign drop_count = '0;
    assign rows_out   = '0;
`endif

endmodule

// File: tb/tb_mha_result_collector.sv
// Testbench for mha_result_collector (DATA_WIDTH=16, BLOCK_SIZE=2, COL_Y=2).
// Expected tiles are queued as captures are driven and checked in order as the
// DUT hands them out; counter expectations follow MHA_COLLECTOR_PERF_CNT_EN.
module tb_mha_result_collector;

    localparam int DW     = 16;
    localparam int BS     = 2;
    localparam int COLS   = 2;
    localparam int TW     = DW * BS * BS;
    localparam int CW     = 1;

`ifdef MHA_COLLECTOR_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          acc_done_wrap;
    logic [TW-1:0] in_tile;
    logic          m_valid;
    logic          m_ready;
    logic [TW-1:0] m_data;
    logic [CW-1:0] m_col_idx;
    logic          m_last;
    logic          overflow;
    logic [15:0]   drop_count;
    logic [15:0]   rows_out;

    mha_result_collector #(
        .DATA_WIDTH (DW),
        .BLOCK_SIZE (BS),
        .COL_Y      (COLS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .acc_done_wrap (acc_done_wrap),
        .in_tile       (in_tile),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_col_idx     (m_col_idx),
        .m_last        (m_last),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .rows_out      (rows_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] data;
        int unsigned   col;
        bit            last;
    } exp_t;

    typedef struct {
        logic [TW-1:0] t0;
        logic [TW-1:0] t1;
        int unsigned   stall;
    } vec_t;

    exp_t        sb[$];
    int unsigned n_vec    = 0;
    int unsigned n_bad    = 0;
    int unsigned acc_cnt  = 0;
    int unsigned rows_exp = 0;
    bit          stalled  = 1'b0;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [TW-1:0] t);
        exp_t e;
        e.data = t;
        e.col  = acc_cnt % COLS;
        e.last = ((acc_cnt % COLS) == COLS - 1);
        sb.push_back(e);
        acc_cnt++;
    endtask

    // One-cycle acc_done pulse; the tile is sampled at the second edge
    task automatic capture(input logic [TW-1:0] t, input bit accepted);
        @(posedge clk); #1;
        acc_done_wrap = 1'b1;
        in_tile       = t;
        @(posedge clk); #1;
        acc_done_wrap = 1'b0;
        in_tile       = ~t;
        if (accepted) push(t);
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        while ((sb.size() != 0 || m_valid) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_done", TW'(sb.size() == 0 && !m_valid), 1);
    endtask

    function automatic logic [15:0] exp_rows();
        return PERF ? 16'(rows_exp) : 16'd0;
    endfunction

    // Output monitor: sampled at the falling edge, between active edges
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check("valid_hold", TW'(m_valid), 1);
            if (m_valid) begin
                check("tile_expected", TW'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    check("m_data", m_data, sb[0].data);
                    check("m_col_idx", TW'(m_col_idx), TW'(sb[0].col));
                    check("m_last", TW'(m_last), TW'(sb[0].last));
                    if (m_ready) begin
                        if (sb[0].last) rows_exp++;
                        void'(sb.pop_front());
                    end
                end
            end
            stalled = m_valid && !m_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[3];
        tbl[0] = '{64'hB000_B001_B002_B003, 64'hB100_B101_B102_B103, 10};
        tbl[1] = '{64'hC0C0_0000_FFFF_8001, 64'h7FFF_8000_0001_FFFE, 0};
        tbl[2] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3};

        rst_n         = 1'b0;
        acc_done_wrap = 1'b0;
        m_ready       = 1'b1;
        in_tile       = '0;

        // Reset state
        #12;
        check("rst_m_valid", TW'(m_valid), 0);
        check("rst_m_last", TW'(m_last), 0);
        check("rst_m_col_idx", TW'(m_col_idx), 0);
        check("rst_m_data", m_data, 0);
        check("rst_overflow", TW'(overflow), 0);
        check("rst_drop_count", TW'(drop_count), 0);
        check("rst_rows_out", TW'(rows_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic row with latency check on the closing capture
        capture(64'hA000_A001_A002_A003, 1'b1);
        @(posedge clk); #1;
        acc_done_wrap = 1'b1;
        in_tile       = 64'hBBBB_0001_0002_0003;
        @(posedge clk); #1;
        acc_done_wrap = 1'b0;
        push(64'hBBBB_0001_0002_0003);
        check("latency_edge_n", TW'(m_valid), 0);
        @(posedge clk); #1;
        check("latency_edge_n1", TW'(m_valid), 1);
        check("latency_col0", TW'(m_col_idx), 0);
        wait_drain();
        check("basic_rows_out", TW'(rows_out), TW'(exp_rows()));

        // Table-driven rows with varying backpressure
        for (int i = 0; i < 3; i++) begin
            m_ready = 1'b0;
            capture(tbl[i].t0, 1'b1);
            capture(tbl[i].t1, 1'b1);
            repeat (tbl[i].stall) @(posedge clk);
            #1 m_ready = 1'b1;
            wait_drain();
        end
        check("tbl_rows_out", TW'(rows_out), TW'(exp_rows()));

        // Final handshake of a row coincides with a capture into that buffer
        m_ready = 1'b0;
        capture(64'h5101_0000_0000_0001, 1'b1);
        capture(64'h5101_0000_0000_0002, 1'b1);
        capture(64'h5101_0000_0000_0003, 1'b1);
        capture(64'h5101_0000_0000_0004, 1'b1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        acc_done_wrap = 1'b1;
        in_tile       = 64'h5101_0000_0000_0005;
        @(posedge clk); #1;
        acc_done_wrap = 1'b0;
        m_ready       = 1'b0;
        push(64'h5101_0000_0000_0005);
        check("sim_overflow", TW'(overflow), 0);
        check("sim_drop_count", TW'(drop_count), 0);
        m_ready = 1'b1;
        capture(64'h5101_0000_0000_0006, 1'b1);
        wait_drain();
        check("sim_overflow_after", TW'(overflow), 0);

        // Level-held acc_done_wrap: only the first cycle captures
        @(posedge clk); #1;
        acc_done_wrap = 1'b1;
        in_tile       = 64'h1E7E_1000_0000_0001;
        push(64'h1E7E_1000_0000_0001);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_tile = 64'hDEAD_0000_0000_0000 | 64'(i + 2);
        end
        acc_done_wrap = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("level_single_capture", TW'(m_valid), 0);
        capture(64'h1E7E_1000_0000_0007, 1'b1);
        wait_drain();

        // Overflow: both buffers full, fifth tile dropped
        m_ready = 1'b0;
        capture(64'h0F00_0000_0000_0001, 1'b1);
        capture(64'h0F00_0000_0000_0002, 1'b1);
        capture(64'h0F00_0000_0000_0003, 1'b1);
        capture(64'h0F00_0000_0000_0004, 1'b1);
        capture(64'h0F00_0000_0000_0005, 1'b0);
        check("ovf_overflow", TW'(overflow), 1);
        check("ovf_drop_count", TW'(drop_count), PERF ? 1 : 0);
        check("ovf_m_valid", TW'(m_valid), 1);
        #1 m_ready = 1'b1;
        wait_drain();
        check("ovf_rows_out", TW'(rows_out), TW'(exp_rows()));
        check("ovf_sticky", TW'(overflow), 1);

        // Asynchronous reset in the middle of a row drain
        m_ready = 1'b0;
        capture(64'h2E5E_0000_0000_0001, 1'b1);
        capture(64'h2E5E_0000_0000_0002, 1'b1);
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1 m_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_m_valid", TW'(m_valid), 0);
        check("arst_m_data", m_data, 0);
        check("arst_m_last", TW'(m_last), 0);
        check("arst_m_col_idx", TW'(m_col_idx), 0);
        check("arst_overflow", TW'(overflow), 0);
        check("arst_drop_count", TW'(drop_count), 0);
        check("arst_rows_out", TW'(rows_out), 0);
        sb.delete();
        acc_cnt  = 0;
        rows_exp = 0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("arst_no_stale", TW'(m_valid), 0);
        capture(64'h9E00_0000_0000_0001, 1'b1);
        capture(64'h9E00_0000_0000_0002, 1'b1);
        wait_drain();
        check("arst_rows_out_after", TW'(rows_out), TW'(exp_rows()));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
